// File: rtl/soc_riscv_termination_monitor.sv
// ---------------------------------------------------------------------------
// soc_riscv_termination_monitor
//
// Run-control monitor for multi-core compute-tile benches and FPGA self-test.
// Each core's retirement trace is watched for the termination marker
// instruction. The monitor shadows every core's x3 (r3) so that the exit code
// can be latched when the core terminates. It also summarises global
// completion and failure, and runs an idle watchdog that flags a hung system.
//
// Ports
//   clk           system clock, the only clock
//   rst_n         asynchronous active-low reset
//   trace_valid   [NUM_CORES]     core i retired one instruction this cycle
//   trace_insn    [NUM_CORES*32]  retired instruction, core i at [32*i +: 32]
//   trace_wben    [NUM_CORES]     retiring instruction writes a GPR
//   trace_wbreg   [NUM_CORES*5]   destination register index
//   trace_wbdata  [NUM_CORES*32]  destination write data
//   term_mask     [NUM_CORES]     sticky: core i executed TERM_INSN
//   term_count    popcount of term_mask & CORE_MASK (registered)
//   exit_code     [NUM_CORES*32]  r3 latched at core i termination
//   all_done      every CORE_MASK core has terminated (registered)
//   any_fail      some terminated masked core has a non-zero exit code
//   fail_core     lowest-index failing core, valid while any_fail
//   timeout       watchdog expired before all_done
// ---------------------------------------------------------------------------
module soc_riscv_termination_monitor #(
  parameter int                   NUM_CORES      = 1,
  parameter logic [31:0]          TERM_INSN      = 32'h0010_0013,
  parameter logic [NUM_CORES-1:0] CORE_MASK      = '1,
  parameter int unsigned          TIMEOUT_CYCLES = 0,
  parameter int                   CNT_W          = 32,
  localparam int                  TC_W           = $clog2(NUM_CORES + 1),
  localparam int                  FC_W           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    trace_valid,
  input  logic [NUM_CORES*32-1:0] trace_insn,
  input  logic [NUM_CORES-1:0]    trace_wben,
  input  logic [NUM_CORES*5-1:0]  trace_wbreg,
  input  logic [NUM_CORES*32-1:0] trace_wbdata,
  output logic [NUM_CORES-1:0]    term_mask,
  output logic [TC_W-1:0]         term_count,
  output logic [NUM_CORES*32-1:0] exit_code,
  output logic                    all_done,
  output logic                    any_fail,
  output logic [FC_W-1:0]         fail_core,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  // Per-core state; element i of a packed array sits at [32*i +: 32],
  // matching the flattened exit_code layout.
  logic [NUM_CORES-1:0][31:0] r3_q, r3_d;
  logic [NUM_CORES-1:0][31:0] exit_q, exit_d;
  logic [NUM_CORES-1:0]       term_mask_q, term_mask_d;
  logic [NUM_CORES-1:0]       x3_wr, term_hit;

  logic [TC_W-1:0]            count_d;
  logic                       all_done_d, any_fail_d;
  logic [FC_W-1:0]            fail_core_d;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           wd_q, wd_d;
  logic                       wd_expire, timeout_d;

  // Per-core shadow and termination capture.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    r3_d     = r3_q;
    exit_d   = exit_q;
    x3_wr    = '0;
    term_hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      x3_wr[i]    = trace_valid[i] & trace_wben[i] & (trace_wbreg[5*i +: 5] == 5'd3);
      term_hit[i] = trace_valid[i] & (trace_insn[32*i +: 32] == TERM_INSN) & ~term_mask_q[i];
      if (x3_wr[i]) r3_d[i] = trace_wbdata[32*i +: 32];
      // r3_d already carries this beat's x3 write, which gives the bypass
      // when the terminating beat itself writes x3.
      if (term_hit[i]) exit_d[i] = r3_d[i];
    end
  end

  assign term_mask_d = term_mask_q | term_hit;

  // Summary flags are computed from the registered term_mask/exit_code, so
  // they trail the termination beat by one cycle.
  always_comb begin
    count_d     = '0;
    any_fail_d  = 1'b0;
    fail_core_d = '0;
    all_done_d  = &(term_mask_q | ~CORE_MASK);
    // Scan from the top so the lowest failing index is written last and wins.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (CORE_MASK[i] && term_mask_q[i]) begin
        count_d = count_d + TC_W'(1);
        if (exit_q[i] != '0) begin
          any_fail_d  = 1'b1;
          fail_core_d = FC_W'(i);
        end
      end
    end
  end

  // Watchdog expiry: the counter has already seen TIMEOUT_CYCLES-1 idle
  // cycles and this cycle is idle as well.
  assign wd_expire = WD_EN && (wd_q == WD_LAST) && !(|trace_valid);

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout;
    unique case (state_q)
      ST_RUN: begin
        // Completion is evaluated first so it wins over a simultaneous expiry.
        if (all_done_d) begin
          state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
        if (WD_EN) begin
          if (|trace_valid)    wd_d = '0;
          else if (wd_q != '1) wd_d = wd_q + CNT_W'(1);
        end
      end
      default: ;  // DONE and TIMEOUT hold until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-core shadow and exit-code arrays are reset too, because
      // a reset mid-run must not leave stale exit codes visible.
      r3_q        <= '0;
      exit_q      <= '0;
      term_mask_q <= '0;
      term_count  <= '0;
      all_done    <= 1'b0;
      any_fail    <= 1'b0;
      fail_core   <= '0;
      timeout     <= 1'b0;
      wd_q        <= '0;
      state_q     <= ST_RUN;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      r3_q        <= r3_d;
      exit_q      <= exit_d;
      term_mask_q <= term_mask_d;
      term_count  <= count_d;
      all_done    <= all_done_d;
      any_fail    <= any_fail_d;
      fail_core   <= fail_core_d;
      timeout     <= timeout_d;
      wd_q        <= wd_d;
      state_q     <= state_d;
    end
  end

  assign term_mask = term_mask_q;
  assign exit_code = exit_q;

endmodule

// File: tb/tb_soc_riscv_termination_monitor.sv
// ---------------------------------------------------------------------------
// Directed bench for soc_riscv_termination_monitor.
// Instances:
//   u_a : 1 core, watchdog off
//   u_d : 1 core, TIMEOUT_CYCLES=8
//   u_e : 1 core, TIMEOUT_CYCLES=1 (completion vs expiry on the same edge)
//   u_b : 4 cores, all masked
//   u_c : 4 cores, CORE_MASK=4'b0011
// The 1-core instances share one stimulus set, and the 4-core ones share another.
// ---------------------------------------------------------------------------
module tb_soc_riscv_termination_monitor;

  localparam logic [31:0] TERM    = 32'h0010_0013;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADDI_X3 = 32'h0000_0193;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // single-core stimulus
  logic        s_valid, s_wben;
  logic [31:0] s_insn, s_wbdata;
  logic [4:0]  s_wbreg;
  // four-core stimulus
  logic [3:0]   m_valid, m_wben;
  logic [127:0] m_insn, m_wbdata;
  logic [19:0]  m_wbreg;

  logic [0:0]  a_term_mask, a_term_count, a_fail_core;
  logic [31:0] a_exit;
  logic        a_all_done, a_any_fail, a_timeout;
  logic [0:0]  d_term_mask, d_term_count, d_fail_core;
  logic [31:0] d_exit;
  logic        d_all_done, d_any_fail, d_timeout;
  logic [0:0]  e_term_mask, e_term_count, e_fail_core;
  logic [31:0] e_exit;
  logic        e_all_done, e_any_fail, e_timeout;
  logic [3:0]   b_term_mask, c_term_mask;
  logic [2:0]   b_term_count, c_term_count;
  logic [127:0] b_exit, c_exit;
  logic         b_all_done, b_any_fail, b_timeout, c_all_done, c_any_fail, c_timeout;
  logic [1:0]   b_fail_core, c_fail_core;

  soc_riscv_termination_monitor #(.NUM_CORES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .trace_valid(s_valid), .trace_insn(s_insn), .trace_wben(s_wben),
    .trace_wbreg(s_wbreg), .trace_wbdata(s_wbdata), .term_mask(a_term_mask),
    .term_count(a_term_count), .exit_code(a_exit), .all_done(a_all_done),
    .any_fail(a_any_fail), .fail_core(a_fail_core), .timeout(a_timeout));

  soc_riscv_termination_monitor #(.NUM_CORES(1), .TIMEOUT_CYCLES(8)) u_d (
    .clk(clk), .rst_n(rst_n), .trace_valid(s_valid), .trace_insn(s_insn), .trace_wben(s_wben),
    .trace_wbreg(s_wbreg), .trace_wbdata(s_wbdata), .term_mask(d_term_mask),
    .term_count(d_term_count), .exit_code(d_exit), .all_done(d_all_done),
    .any_fail(d_any_fail), .fail_core(d_fail_core), .timeout(d_timeout));

  soc_riscv_termination_monitor #(.NUM_CORES(1), .TIMEOUT_CYCLES(1)) u_e (
    .clk(clk), .rst_n(rst_n), .trace_valid(s_valid), .trace_insn(s_insn), .trace_wben(s_wben),
    .trace_wbreg(s_wbreg), .trace_wbdata(s_wbdata), .term_mask(e_term_mask),
    .term_count(e_term_count), .exit_code(e_exit), .all_done(e_all_done),
    .any_fail(e_any_fail), .fail_core(e_fail_core), .timeout(e_timeout));

  soc_riscv_termination_monitor #(.NUM_CORES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .trace_valid(m_valid), .trace_insn(m_insn), .trace_wben(m_wben),
    .trace_wbreg(m_wbreg), .trace_wbdata(m_wbdata), .term_mask(b_term_mask),
    .term_count(b_term_count), .exit_code(b_exit), .all_done(b_all_done),
    .any_fail(b_any_fail), .fail_core(b_fail_core), .timeout(b_timeout));

  soc_riscv_termination_monitor #(.NUM_CORES(4), .CORE_MASK(4'b0011)) u_c (
    .clk(clk), .rst_n(rst_n), .trace_valid(m_valid), .trace_insn(m_insn), .trace_wben(m_wben),
    .trace_wbreg(m_wbreg), .trace_wbdata(m_wbdata), .term_mask(c_term_mask),
    .term_count(c_term_count), .exit_code(c_exit), .all_done(c_all_done),
    .any_fail(c_any_fail), .fail_core(c_fail_core), .timeout(c_timeout));

  // ---------------- stimulus helpers ----------------
  task automatic s_idle();
    s_valid = 1'b0; s_wben = 1'b0; s_insn = '0; s_wbreg = '0; s_wbdata = '0;
  endtask

  task automatic m_idle();
    m_valid = '0; m_wben = '0; m_insn = '0; m_wbreg = '0; m_wbdata = '0;
  endtask

  task automatic s_beat(input logic [31:0] insn, input logic wben, input logic [4:0] wreg,
                        input logic [31:0] data);
    s_valid = 1'b1; s_insn = insn; s_wben = wben; s_wbreg = wreg; s_wbdata = data;
  endtask

  task automatic m_beat(input int c, input logic [31:0] insn, input logic wben,
                        input logic [4:0] wreg, input logic [31:0] data);
    m_valid[c] = 1'b1; m_insn[32*c +: 32] = insn; m_wben[c] = wben;
    m_wbreg[5*c +: 5] = wreg; m_wbdata[32*c +: 32] = data;
  endtask

  // One clock edge; outputs are sampled 1 ns later and inputs return to idle.
  task automatic tick();
    @(posedge clk); #1;
    s_idle(); m_idle();
  endtask

  // After this task the next rising edge is "edge 1" after release.
  task automatic do_reset();
    s_idle(); m_idle();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_idle(); m_idle();
    @(posedge clk); #1 rst_n = 1'b0; #1;
    vectors++; if (b_term_mask !== 4'b0) begin miscompares++; $display("FAIL reset term_mask: got %h want 0", b_term_mask); end
    vectors++; if (b_term_count !== 3'd0) begin miscompares++; $display("FAIL reset term_count: got %0d want 0", b_term_count); end
    vectors++; if (b_exit !== 128'h0) begin miscompares++; $display("FAIL reset exit_code: got %h want 0", b_exit); end
    vectors++; if ({b_all_done, b_any_fail, b_timeout} !== 3'b000) begin miscompares++; $display("FAIL reset flags: got %b want 000", {b_all_done, b_any_fail, b_timeout}); end
    vectors++; if (b_fail_core !== 2'd0) begin miscompares++; $display("FAIL reset fail_core: got %0d want 0", b_fail_core); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    vectors++; if (b_all_done !== 1'b0) begin miscompares++; $display("FAIL reset idle all_done: got %b want 0", b_all_done); end
  endtask

  task automatic test_single();
    do_reset();
    s_beat(ADDI_X3, 1'b1, 5'd3, 32'h0); tick();      // edge 1: x3 <= 0
    s_beat(TERM, 1'b0, 5'd0, 32'h0); tick();         // edge 2: termination
    vectors++; if (a_term_mask !== 1'b1) begin miscompares++; $display("FAIL single term_mask: got %b want 1", a_term_mask); end
    vectors++; if (a_all_done !== 1'b0) begin miscompares++; $display("FAIL single all_done early: got %b want 0", a_all_done); end
    tick();                                          // edge 3
    vectors++; if (a_all_done !== 1'b1) begin miscompares++; $display("FAIL single all_done: got %b want 1", a_all_done); end
    vectors++; if (a_exit !== 32'h0) begin miscompares++; $display("FAIL single exit_code: got %h want 0", a_exit); end
    vectors++; if (a_any_fail !== 1'b0) begin miscompares++; $display("FAIL single any_fail: got %b want 0", a_any_fail); end
    vectors++; if (a_term_count !== 1'b1) begin miscompares++; $display("FAIL single term_count: got %0d want 1", a_term_count); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    m_beat(2, ADDI_X3, 1'b1, 5'd3, 32'd5); m_beat(3, ADDI_X3, 1'b1, 5'd3, 32'd7); tick();
    m_beat(3, ADDI_X3, 1'b1, 5'd3, 32'd0); m_beat(2, NOP, 1'b1, 5'd4, 32'd9); tick();
    m_beat(2, TERM, 1'b0, 5'd0, 32'd0); m_beat(3, TERM, 1'b0, 5'd0, 32'd0); tick();
    vectors++; if (b_term_mask !== 4'b1100) begin miscompares++; $display("FAIL same term_mask: got %b want 1100", b_term_mask); end
    vectors++; if (b_term_count !== 3'd0) begin miscompares++; $display("FAIL same term_count lat: got %0d want 0", b_term_count); end
    vectors++; if (b_exit[64 +: 32] !== 32'd5) begin miscompares++; $display("FAIL same exit2: got %h want 5", b_exit[64 +: 32]); end
    vectors++; if (b_exit[96 +: 32] !== 32'd0) begin miscompares++; $display("FAIL same exit3: got %h want 0", b_exit[96 +: 32]); end
    tick();
    vectors++; if (b_term_count !== 3'd2) begin miscompares++; $display("FAIL same term_count 2: got %0d want 2", b_term_count); end
    vectors++; if (b_any_fail !== 1'b1) begin miscompares++; $display("FAIL same any_fail: got %b want 1", b_any_fail); end
    vectors++; if (b_fail_core !== 2'd2) begin miscompares++; $display("FAIL same fail_core: got %0d want 2", b_fail_core); end
    vectors++; if (b_all_done !== 1'b0) begin miscompares++; $display("FAIL same all_done early: got %b want 0", b_all_done); end
    m_beat(0, TERM, 1'b0, 5'd0, 32'd0); m_beat(1, TERM, 1'b0, 5'd0, 32'd0); tick();
    vectors++; if (b_term_mask !== 4'b1111) begin miscompares++; $display("FAIL same term_mask all: got %b want 1111", b_term_mask); end
    vectors++; if (b_all_done !== 1'b0) begin miscompares++; $display("FAIL same all_done lat: got %b want 0", b_all_done); end
    tick();
    vectors++; if (b_term_count !== 3'd4) begin miscompares++; $display("FAIL same term_count 4: got %0d want 4", b_term_count); end
    vectors++; if (b_all_done !== 1'b1) begin miscompares++; $display("FAIL same all_done: got %b want 1", b_all_done); end
    vectors++; if (b_fail_core !== 2'd2) begin miscompares++; $display("FAIL same fail_core end: got %0d want 2", b_fail_core); end
    vectors++; if (b_timeout !== 1'b0) begin miscompares++; $display("FAIL same timeout: got %b want 0", b_timeout); end
  endtask

  task automatic test_bypass();
    do_reset();
    m_beat(3, ADDI_X3, 1'b1, 5'd3, 32'd5); m_beat(1, ADDI_X3, 1'b1, 5'd3, 32'd1); tick();
    m_beat(1, TERM, 1'b1, 5'd3, 32'hDEAD); m_beat(3, TERM, 1'b0, 5'd0, 32'd0); tick();
    vectors++; if (b_exit[32 +: 32] !== 32'hDEAD) begin miscompares++; $display("FAIL bypass exit1: got %h want dead", b_exit[32 +: 32]); end
    vectors++; if (b_exit[96 +: 32] !== 32'd5) begin miscompares++; $display("FAIL bypass exit3: got %h want 5", b_exit[96 +: 32]); end
    vectors++; if (b_term_mask !== 4'b1010) begin miscompares++; $display("FAIL bypass term_mask: got %b want 1010", b_term_mask); end
    tick();
    vectors++; if (b_fail_core !== 2'd1) begin miscompares++; $display("FAIL bypass fail_core lowest: got %0d want 1", b_fail_core); end
    m_beat(1, ADDI_X3, 1'b1, 5'd3, 32'd1); tick();
    m_beat(1, TERM, 1'b1, 5'd3, 32'd1); tick();
    vectors++; if (b_exit[32 +: 32] !== 32'hDEAD) begin miscompares++; $display("FAIL bypass no overwrite: got %h want dead", b_exit[32 +: 32]); end
    tick();
    vectors++; if (b_term_count !== 3'd2) begin miscompares++; $display("FAIL bypass term_count: got %0d want 2", b_term_count); end
  endtask

  task automatic test_mask();
    do_reset();
    m_beat(0, TERM, 1'b0, 5'd0, 32'd0); m_beat(1, TERM, 1'b0, 5'd0, 32'd0); tick();
    vectors++; if (c_term_mask !== 4'b0011) begin miscompares++; $display("FAIL mask term_mask: got %b want 0011", c_term_mask); end
    vectors++; if (c_all_done !== 1'b0) begin miscompares++; $display("FAIL mask all_done lat: got %b want 0", c_all_done); end
    tick();
    vectors++; if (c_all_done !== 1'b1) begin miscompares++; $display("FAIL mask all_done: got %b want 1", c_all_done); end
    vectors++; if (c_term_count !== 3'd2) begin miscompares++; $display("FAIL mask term_count: got %0d want 2", c_term_count); end
    m_beat(3, ADDI_X3, 1'b1, 5'd3, 32'd9); tick();
    m_beat(3, TERM, 1'b0, 5'd0, 32'd0); tick();
    vectors++; if (c_term_mask !== 4'b1011) begin miscompares++; $display("FAIL mask late term_mask: got %b want 1011", c_term_mask); end
    vectors++; if (c_exit[96 +: 32] !== 32'd9) begin miscompares++; $display("FAIL mask late exit3: got %h want 9", c_exit[96 +: 32]); end
    tick();
    vectors++; if (c_any_fail !== 1'b0) begin miscompares++; $display("FAIL mask any_fail: got %b want 0", c_any_fail); end
    vectors++; if (c_term_count !== 3'd2) begin miscompares++; $display("FAIL mask term_count end: got %0d want 2", c_term_count); end
  endtask

  task automatic test_timeout();
    logic exp;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k == 8);
      vectors++; if (d_timeout !== exp) begin miscompares++; $display("FAIL wd edge %0d: got %b want %b", k, d_timeout, exp); end
    end
    repeat (3) tick();
    vectors++; if (d_timeout !== 1'b1) begin miscompares++; $display("FAIL wd held: got %b want 1", d_timeout); end
    vectors++; if (d_all_done !== 1'b0) begin miscompares++; $display("FAIL wd all_done: got %b want 0", d_all_done); end
    vectors++; if (a_timeout !== 1'b0) begin miscompares++; $display("FAIL wd disabled: got %b want 0", a_timeout); end
    s_beat(TERM, 1'b1, 5'd3, 32'h2A); tick();
    vectors++; if (d_term_mask !== 1'b1) begin miscompares++; $display("FAIL wd late term_mask: got %b want 1", d_term_mask); end
    vectors++; if (d_exit !== 32'h2A) begin miscompares++; $display("FAIL wd late exit: got %h want 2a", d_exit); end
    tick();
    vectors++; if (d_timeout !== 1'b1) begin miscompares++; $display("FAIL wd sticky: got %b want 1", d_timeout); end
  endtask

  task automatic test_timeout_restart();
    logic exp;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      if (k == 7) s_beat(NOP, 1'b0, 5'd0, 32'd0);
      tick();
      exp = (k == 15);
      vectors++; if (d_timeout !== exp) begin miscompares++; $display("FAIL wd restart edge %0d: got %b want %b", k, d_timeout, exp); end
    end
  endtask

  task automatic test_done_wins();
    do_reset();
    s_beat(TERM, 1'b1, 5'd3, 32'd0); tick();
    vectors++; if ({e_term_mask, e_timeout} !== 2'b10) begin miscompares++; $display("FAIL race edge1: got %b want 10", {e_term_mask, e_timeout}); end
    tick();
    vectors++; if ({e_all_done, e_timeout} !== 2'b10) begin miscompares++; $display("FAIL race done wins: got %b want 10", {e_all_done, e_timeout}); end
    repeat (3) tick();
    vectors++; if (e_timeout !== 1'b0) begin miscompares++; $display("FAIL race timeout later: got %b want 0", e_timeout); end
  endtask

  task automatic test_async_reset();
    logic exp;
    do_reset();
    m_beat(0, TERM, 1'b0, 5'd0, 32'd0); m_beat(2, TERM, 1'b1, 5'd3, 32'd4); tick();
    repeat (7) tick();
    vectors++; if (b_term_mask !== 4'b0101) begin miscompares++; $display("FAIL arst pre term_mask: got %b want 0101", b_term_mask); end
    vectors++; if ({b_any_fail, b_fail_core} !== 3'b110) begin miscompares++; $display("FAIL arst pre fail: got %b want 110", {b_any_fail, b_fail_core}); end
    vectors++; if (d_timeout !== 1'b1) begin miscompares++; $display("FAIL arst pre timeout: got %b want 1", d_timeout); end
    #2 rst_n = 1'b0; #1;
    vectors++; if (b_term_mask !== 4'b0) begin miscompares++; $display("FAIL arst term_mask: got %b want 0", b_term_mask); end
    vectors++; if (b_term_count !== 3'd0) begin miscompares++; $display("FAIL arst term_count: got %0d want 0", b_term_count); end
    vectors++; if (b_exit !== 128'h0) begin miscompares++; $display("FAIL arst exit_code: got %h want 0", b_exit); end
    vectors++; if ({b_all_done, b_any_fail, b_fail_core} !== 4'b0) begin miscompares++; $display("FAIL arst flags: got %b want 0000", {b_all_done, b_any_fail, b_fail_core}); end
    vectors++; if (d_timeout !== 1'b0) begin miscompares++; $display("FAIL arst timeout: got %b want 0", d_timeout); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k == 8);
      vectors++; if (d_timeout !== exp) begin miscompares++; $display("FAIL arst rerun edge %0d: got %b want %b", k, d_timeout, exp); end
    end
  endtask

  initial begin
    s_idle();
    m_idle();
    test_reset();
    test_single();
    test_same_cycle();
    test_bypass();
    test_mask();
    test_timeout();
    test_timeout_restart();
    test_done_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
